// File: rtl/aes_inv_key_sched.sv
// AES-128 decryption key scheduler: expands the cipher key forward to round 10,
// then walks back one round key per accepted 'next' using a single shared SubWord.
module aes_inv_key_sched (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic         next,
    output logic         busy,
    output logic         rk_valid,
    output logic [127:0] rk_out,
    output logic [3:0]   round_idx,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, EXPAND, STEP} state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_rot(input logic [31:0] x);
        logic [31:0] rot;
        rot = {x[23:0], x[31:24]};
        return {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t       r_state, w_state_nxt;
    logic [127:0] r_key, w_key_nxt;
    logic [3:0]   r_rcon_idx, w_rcon_nxt;
    logic [3:0]   r_round, w_round_nxt;
    logic         r_valid, w_valid_nxt;
    logic         r_done, w_done_nxt;
    logic [127:0] r_rk, w_rk_nxt;

    logic [31:0]  w_k0, w_k1, w_k2, w_k3;
    logic         w_fwd_dir;
    logic [31:0]  w_sub_in, w_t;
    logic [3:0]   w_rc_idx;
    logic [31:0]  w_f0, w_f1, w_f2, w_f3;
    logic [31:0]  w_i0, w_i1, w_i2, w_i3;
    logic [127:0] w_fwd, w_inv;

    assign {w_k0, w_k1, w_k2, w_k3} = r_key;

    // One SubWord serves both directions: forward feeds w3, inverse feeds the
    // recovered w3' = w7^w6 of the previous round.
    assign w_fwd_dir = (r_state == EXPAND);
    assign w_sub_in  = w_fwd_dir ? w_k3 : (w_k3 ^ w_k2);
    assign w_rc_idx  = w_fwd_dir ? r_rcon_idx : (r_round - 4'd1);
    assign w_t       = sub_rot(w_sub_in) ^ {rcon(w_rc_idx), 24'h0};

    assign w_f0  = w_k0 ^ w_t;
    assign w_f1  = w_f0 ^ w_k1;
    assign w_f2  = w_f1 ^ w_k2;
    assign w_f3  = w_f2 ^ w_k3;
    assign w_fwd = {w_f0, w_f1, w_f2, w_f3};

    assign w_i3  = w_k3 ^ w_k2;
    assign w_i2  = w_k2 ^ w_k1;
    assign w_i1  = w_k1 ^ w_k0;
    assign w_i0  = w_k0 ^ w_t;
    assign w_inv = {w_i0, w_i1, w_i2, w_i3};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_key      <= '0;
            r_rcon_idx <= '0;
            r_round    <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_rk       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_key      <= w_key_nxt;
            r_rcon_idx <= w_rcon_nxt;
            r_round    <= w_round_nxt;
            r_valid    <= w_valid_nxt;
            r_done     <= w_done_nxt;
            r_rk       <= w_rk_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_rcon_nxt  = r_rcon_idx;
        w_round_nxt = r_round;
        w_valid_nxt = r_valid;
        w_done_nxt  = 1'b0;
        w_rk_nxt    = r_rk;
        if (key_load) begin
            w_state_nxt = EXPAND;
            w_key_nxt   = key_in;
            w_rcon_nxt  = '0;
            w_round_nxt = '0;
            w_valid_nxt = 1'b0;
            w_rk_nxt    = '0;
        end else begin
            case (r_state)
                EXPAND: begin
                    w_key_nxt  = w_fwd;
                    w_rcon_nxt = r_rcon_idx + 4'd1;
                    if (r_rcon_idx == 4'd9) begin
                        w_state_nxt = STEP;
                        w_round_nxt = 4'd10;
                        w_valid_nxt = 1'b1;
                        w_rk_nxt    = w_fwd;
                    end
                end
                STEP: begin
                    if (next) begin
                        if (r_round != 4'd0) begin
                            w_key_nxt   = w_inv;
                            w_round_nxt = r_round - 4'd1;
                            w_rk_nxt    = w_inv;
                        end else begin
                            w_state_nxt = IDLE;
                            w_valid_nxt = 1'b0;
                            w_rk_nxt    = '0;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state == EXPAND);
    assign rk_valid  = r_valid;
    assign rk_out    = r_rk;
    assign round_idx = r_round;
    assign done      = r_done;
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched using the FIPS-197 A.1 key schedule.
module tb_aes_inv_key_sched;
    logic         clk = 1'b0;
    logic         rst, key_load, next;
    logic [127:0] key_in;
    logic         busy, rk_valid, done;
    logic [127:0] rk_out;
    logic [3:0]   round_idx;

    int n_chk = 0;
    int n_err = 0;
    logic saw_done = 1'b0;
    logic [127:0] rk_exp [0:10];

    localparam logic [127:0] K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes_inv_key_sched dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load), .next(next),
        .busy(busy), .rk_valid(rk_valid), .rk_out(rk_out), .round_idx(round_idx),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done) saw_done = 1'b1;
    endtask

    // Pulse key_load and wait (bounded) for rk_valid; reports edges taken.
    task automatic load_wait(input logic [127:0] k, output int n, output int bcnt);
        key_in = k; key_load = 1'b1;
        tick();
        key_load = 1'b0;
        n = 1; bcnt = 0;
        while (!rk_valid && n < 40) begin
            if (busy) bcnt++;
            tick();
            n++;
        end
    endtask

    initial begin
        int n, bcnt, h;
        rk_exp[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk_exp[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk_exp[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk_exp[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk_exp[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk_exp[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk_exp[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk_exp[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk_exp[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk_exp[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk_exp[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst = 1'b1; key_load = 1'b0; next = 1'b0; key_in = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_valid", rk_valid, 0);
        chk("rst_rk", rk_out, 0);
        chk("rst_round", round_idx, 0);
        chk("rst_done", done, 0);

        // Nominal expansion with next held high from IDLE onward.
        next = 1'b1;
        load_wait(K, n, bcnt);
        chk("nom_lat", n, 11);
        chk("nom_busycnt", bcnt, 10);
        chk("nom_busy_off", busy, 0);
        for (int i = 10; i >= 0; i--) begin
            chk($sformatf("nom_rk%0d", i), rk_out, rk_exp[i]);
            chk($sformatf("nom_idx%0d", i), round_idx, i);
            tick();
        end
        chk("nom_done", done, 1);
        chk("nom_valid_off", rk_valid, 0);
        chk("nom_rk_zero", rk_out, 0);
        tick();
        chk("nom_done_1cyc", done, 0);

        // Backpressure: random stalls between accepted steps.
        next = 1'b0;
        load_wait(K, n, bcnt);
        chk("bp_lat", n, 11);
        for (int i = 10; i >= 0; i--) begin
            h = $urandom_range(0, 20);
            for (int j = 0; j < h; j++) begin
                chk($sformatf("bp_hold%0d", i), rk_out, rk_exp[i]);
                tick();
            end
            chk($sformatf("bp_rk%0d", i), rk_out, rk_exp[i]);
            chk($sformatf("bp_idx%0d", i), round_idx, i);
            next = 1'b1;
            tick();
            next = 1'b0;
        end
        chk("bp_done", done, 1);
        chk("bp_valid_off", rk_valid, 0);
        tick();

        // Restart at round 5 with an all-zero key.
        saw_done = 1'b0;
        next = 1'b1;
        load_wait(K, n, bcnt);
        n = 0;
        while (!(rk_valid && round_idx == 4'd5) && n < 40) begin
            tick();
            n++;
        end
        chk("rs_at5", round_idx, 5);
        next = 1'b0;
        key_in = '0; key_load = 1'b1;
        tick();
        key_load = 1'b0;
        chk("rs_valid_drop", rk_valid, 0);
        chk("rs_rk_zero", rk_out, 0);
        repeat (10) tick();
        chk("rs_valid", rk_valid, 1);
        chk("rs_rk10", rk_out, Z10);
        chk("rs_idx10", round_idx, 10);
        chk("rs_no_done", saw_done, 0);

        // Reset during EXPAND cycle 4, colliding with key_load and next.
        saw_done = 1'b0;
        key_in = K; key_load = 1'b1;
        tick();
        key_load = 1'b0;
        repeat (3) tick();
        chk("ra_busy_pre", busy, 1);
        rst = 1'b1; key_load = 1'b1; next = 1'b1;
        tick();
        rst = 1'b0; key_load = 1'b0;
        chk("ra_busy", busy, 0);
        chk("ra_valid", rk_valid, 0);
        chk("ra_rk", rk_out, 0);
        chk("ra_round", round_idx, 0);
        chk("ra_done", done, 0);
        repeat (3) tick();
        chk("ra_idle_busy", busy, 0);
        chk("ra_idle_valid", rk_valid, 0);
        chk("ra_idle_round", round_idx, 0);
        chk("ra_no_done", saw_done, 0);
        next = 1'b0;
        load_wait(K, n, bcnt);
        chk("ra_lat", n, 11);
        chk("ra_busycnt", bcnt, 10);
        chk("ra_rk10", rk_out, rk_exp[10]);
        chk("ra_idx10", round_idx, 10);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
